// File: rtl/vec_int_pkg.sv
// Shared definitions for the vectored interrupt controller: state encoding,
// default vector base and the cause-index width helper.
package vec_int_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_TAKE    = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0100;

  // Width of a source index; never less than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan upward and keep only the first set bit.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !valid_o) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller for the single-cycle MIPS core.
// IDLE arbitrates masked level requests, TAKE squashes the current
// instruction and redirects the PC to the source vector, SERVICE waits
// for eret. All core-facing strobes decode from registered state only.
module vec_int_ctrl
  import vec_int_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] VEC_BASE  = VEC_BASE_DEFAULT,
  parameter int          VEC_SHIFT = 3,
  localparam int         ID_W      = id_w(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic [31:0]        pc,
  input  logic               eret,
  input  logic               ie_we,
  input  logic               ie_wd,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wd,
  output logic               take_int,
  output logic [31:0]        vector,
  output logic [31:0]        epc,
  output logic               status_ie,
  output logic               in_service,
  output logic [ID_W-1:0]    cause_id
);

  logic [1:0]         state_q, state_d;
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [31:0]        epc_q, epc_d;
  logic [ID_W-1:0]    cause_q, cause_d;

  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    winner;
  logic               any_eligible;

  // Arbitration sees the mask as it stood before any same-cycle write.
  assign eligible = irq_req & mask_q;

  prio_enc #(
    .N (NUM_IRQ),
    .W (ID_W)
  ) u_prio (
    .req_i   (eligible),
    .idx_o   (winner),
    .valid_o (any_eligible)
  );

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    mask_d  = mask_we ? mask_wd : mask_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (ie_we) ie_d = ie_wd;
        // A same-cycle disable write wins over a pending request.
        if (ie_q && any_eligible && !(ie_we && !ie_wd)) begin
          cause_d = winner;
          state_d = ST_TAKE;
        end
      end
      ST_TAKE: begin
        epc_d   = pc;
        ie_d    = 1'b0;
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eret) begin
          ie_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ie_q    <= 1'b0;
      mask_q  <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      mask_q  <= mask_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // One-hot acknowledge to the latched cause while in TAKE.
  always_comb begin
    irq_ack = '0;
    if (state_q == ST_TAKE) irq_ack[cause_q] = 1'b1;
  end

  assign take_int   = (state_q == ST_TAKE);
  assign in_service = (state_q == ST_SERVICE);
  assign vector     = VEC_BASE + (32'(cause_q) << VEC_SHIFT);
  assign epc        = epc_q;
  assign status_ie  = ie_q;
  assign cause_id   = cause_q;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Directed bench for vec_int_ctrl: a per-cycle vector table for the main
// entry/return flow, then hand-written sequences for masking, blocked
// enable writes in service, eret in idle and asynchronous reset.
module tb_vec_int_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_req = '0;
  logic [3:0]  irq_ack;
  logic [31:0] pc = '0;
  logic        eret = 1'b0;
  logic        ie_we = 1'b0;
  logic        ie_wd = 1'b0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wd = '0;
  logic        take_int;
  logic [31:0] vector;
  logic [31:0] epc;
  logic        status_ie;
  logic        in_service;
  logic [1:0]  cause_id;

  int n_checks = 0;
  int n_fail   = 0;

  vec_int_ctrl #(
    .NUM_IRQ   (4),
    .VEC_BASE  (32'h0000_0100),
    .VEC_SHIFT (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .pc         (pc),
    .eret       (eret),
    .ie_we      (ie_we),
    .ie_wd      (ie_wd),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .take_int   (take_int),
    .vector     (vector),
    .epc        (epc),
    .status_ie  (status_ie),
    .in_service (in_service),
    .cause_id   (cause_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        ie_we;
    logic        ie_wd;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        eret;
    logic [31:0] pc;
    logic        e_take;
    logic [3:0]  e_ack;
    logic [31:0] e_vec;
    logic        e_ie;
    logic        e_insvc;
    logic [31:0] e_epc;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] req, input logic iwe, input logic iwd,
                              input logic mwe, input logic [3:0] mwd, input logic er,
                              input logic [31:0] p, input logic tk, input logic [3:0] ak,
                              input logic [31:0] vc, input logic ie, input logic sv,
                              input logic [31:0] ep, input logic [1:0] ca);
    vec_t v;
    v.req = req; v.ie_we = iwe; v.ie_wd = iwd; v.mask_we = mwe; v.mask_wd = mwd;
    v.eret = er; v.pc = p; v.e_take = tk; v.e_ack = ak; v.e_vec = vc; v.e_ie = ie;
    v.e_insvc = sv; v.e_epc = ep; v.e_cause = ca;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic tk, input logic [3:0] ak,
                           input logic [31:0] vc, input logic ie, input logic sv,
                           input logic [31:0] ep, input logic [1:0] ca);
    check({tag, ".take_int"},   32'(take_int),   32'(tk));
    check({tag, ".irq_ack"},    32'(irq_ack),    32'(ak));
    check({tag, ".vector"},     vector,          vc);
    check({tag, ".status_ie"},  32'(status_ie),  32'(ie));
    check({tag, ".in_service"}, 32'(in_service), 32'(sv));
    check({tag, ".epc"},        epc,             ep);
    check({tag, ".cause_id"},   32'(cause_id),   32'(ca));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ie_we = 1'b0; ie_wd = 1'b0; mask_we = 1'b0; mask_wd = '0; eret = 1'b0;
  endtask

  initial begin
    // req, ie_we, ie_wd, mask_we, mask_wd, eret, pc | take, ack, vector, ie, insvc, epc, cause
    tbl.push_back(mk(4'b0000, 1, 1, 1, 4'b1111, 0, 32'h3C,  0, 4'b0000, 32'h100, 1, 0, 32'h00, 2'd0));
    tbl.push_back(mk(4'b0100, 0, 0, 0, 4'b0000, 0, 32'h40,  1, 4'b0100, 32'h110, 1, 0, 32'h00, 2'd2));
    tbl.push_back(mk(4'b0100, 0, 0, 0, 4'b0000, 0, 32'h40,  0, 4'b0000, 32'h110, 0, 1, 32'h40, 2'd2));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 0, 32'h110, 0, 4'b0000, 32'h110, 0, 1, 32'h40, 2'd2));
    tbl.push_back(mk(4'b1010, 0, 0, 0, 4'b0000, 1, 32'h114, 0, 4'b0000, 32'h110, 1, 0, 32'h40, 2'd2));
    tbl.push_back(mk(4'b1010, 0, 0, 0, 4'b0000, 0, 32'h40,  1, 4'b0010, 32'h108, 1, 0, 32'h40, 2'd1));
    tbl.push_back(mk(4'b1010, 0, 0, 0, 4'b0000, 0, 32'h44,  0, 4'b0000, 32'h108, 0, 1, 32'h44, 2'd1));
    tbl.push_back(mk(4'b1000, 0, 0, 0, 4'b0000, 1, 32'h108, 0, 4'b0000, 32'h108, 1, 0, 32'h44, 2'd1));
    tbl.push_back(mk(4'b1000, 0, 0, 0, 4'b0000, 0, 32'h44,  1, 4'b1000, 32'h118, 1, 0, 32'h44, 2'd3));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 0, 32'h48,  0, 4'b0000, 32'h118, 0, 1, 32'h48, 2'd3));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 1, 32'h118, 0, 4'b0000, 32'h118, 1, 0, 32'h48, 2'd3));
    // eret while idle: nothing moves
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 1, 32'h48,  0, 4'b0000, 32'h118, 1, 0, 32'h48, 2'd3));
    tbl.push_back(mk(4'b0000, 0, 0, 1, 4'b1110, 0, 32'h4C,  0, 4'b0000, 32'h118, 1, 0, 32'h48, 2'd3));

    // Reset state
    #12;
    check_all("reset", 0, 4'b0000, 32'h100, 0, 0, 32'h0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      irq_req = tbl[i].req; ie_we = tbl[i].ie_we; ie_wd = tbl[i].ie_wd;
      mask_we = tbl[i].mask_we; mask_wd = tbl[i].mask_wd; eret = tbl[i].eret; pc = tbl[i].pc;
      step();
      check_all($sformatf("row%0d", i), tbl[i].e_take, tbl[i].e_ack, tbl[i].e_vec,
                tbl[i].e_ie, tbl[i].e_insvc, tbl[i].e_epc, tbl[i].e_cause);
    end
    idle_inputs();

    // Masked source 0 never taken
    begin
      int seen = 0;
      irq_req = 4'b0001; pc = 32'h50;
      for (int c = 0; c < 20; c++) begin
        step();
        if (take_int) seen++;
      end
      check("masked.no_take", 32'(seen), 32'd0);
    end
    mask_we = 1'b1; mask_wd = 4'b1111;
    step();
    idle_inputs();
    check("unmask.write_edge_take", 32'(take_int), 32'd0);
    step();
    check_all("unmask.take", 1, 4'b0001, 32'h100, 1, 0, 32'h48, 2'd0);
    pc = 32'h54;
    step();
    irq_req = 4'b0000;
    check_all("unmask.svc", 0, 4'b0000, 32'h100, 0, 1, 32'h54, 2'd0);

    // Enable write ignored in service; new request held pending
    ie_we = 1'b1; ie_wd = 1'b1; irq_req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("svc_iewe%0d.take_int", c), 32'(take_int), 32'd0);
      check($sformatf("svc_iewe%0d.status_ie", c), 32'(status_ie), 32'd0);
    end
    idle_inputs();
    eret = 1'b1; pc = 32'h104;
    step();
    eret = 1'b0; pc = 32'h54;
    check_all("svc_iewe.eret", 0, 4'b0000, 32'h100, 1, 0, 32'h54, 2'd0);
    step();
    check_all("svc_iewe.retake", 1, 4'b0001, 32'h100, 1, 0, 32'h54, 2'd0);
    pc = 32'h58;
    step();
    irq_req = 4'b0000;
    check("pre_reset.in_service", 32'(in_service), 32'd1);

    // Asynchronous reset mid-handler
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 4'b0000, 32'h100, 0, 0, 32'h0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int acks = 0;
      irq_req = 4'b0001;
      for (int c = 0; c < 5; c++) begin
        step();
        if (irq_ack != 4'b0000 || take_int) acks++;
      end
      check("post_reset.no_ack", 32'(acks), 32'd0);
    end

    // Same-cycle disable write blocks an eligible request
    ie_we = 1'b1; ie_wd = 1'b1; mask_we = 1'b1; mask_wd = 4'b1111; irq_req = 4'b0000;
    step();
    ie_we = 1'b1; ie_wd = 1'b0; mask_we = 1'b0; irq_req = 4'b0001;
    step();
    idle_inputs();
    check("block.take_int", 32'(take_int), 32'd0);
    check("block.status_ie", 32'(status_ie), 32'd0);
    step();
    check("block.still_no_take", 32'(take_int), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
